// File: rtl/sub8_seq_pkg.sv
// Shared types and constants for the bit-serial 8-bit subtractor.
// The saturation constants are only consumed when SUB8_SAT_EN is defined.
package sub8_seq_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

  localparam logic [WIDTH-1:0] SAT_POS = 8'h7F;
  localparam logic [WIDTH-1:0] SAT_NEG = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Clamp value for a signed overflow, chosen by the sign of the minuend.
  function automatic logic [WIDTH-1:0] sat_val(input logic a_neg);
    return a_neg ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/sub8_seq_fs.sv
// 1-bit full subtractor: d = x - y - bin, bout set when a borrow is needed.
module sub8_seq_fs (
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = x_i ^ y_i ^ bin_i;
  assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);

endmodule

// File: rtl/sub8_seq.sv
// Bit-serial 8-bit subtractor: one bit per cycle LSB first, result 8 edges after start.
// Define SUB8_SAT_EN to clamp D to 8'h80/8'h7F on signed overflow.
module sub8_seq
  import sub8_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             ovfl
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             ovfl_q, ovfl_d;

  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] raw;
  logic             ovf;

  sub8_seq_fs u_fs (
    .x_i    (a_q[cnt_q]),
    .y_i    (b_q[cnt_q]),
    .bin_i  (brw_q),
    .d_o    (fs_d),
    .bout_o (fs_bout)
  );

  // Partial bits are shifted in from the top so bit 0 lands at D[0] after 8 shifts.
  assign raw = {fs_d, acc_q[WIDTH-1:1]};
  assign ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (raw[WIDTH-1] != a_q[WIDTH-1]);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ovfl_d  = ovfl_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          brw_d   = Bin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = raw;
        brw_d = fs_bout;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          bout_d  = fs_bout;
          ovfl_d  = ovf;
`ifdef SUB8_SAT_EN
          d_d     = ovf ? sat_val(a_q[WIDTH-1]) : raw;
`else
          d_d     = raw;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovfl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovfl_q  <= ovfl_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign D    = d_q;
  assign Bout = bout_q;
  assign ovfl = ovfl_q;

endmodule

// File: tb/tb_sub8_seq.sv
// Randomized self-checking bench for sub8_seq against an arithmetic reference model.
module tb_sub8_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, Bin;
  logic [7:0] A, B;
  logic       busy, done, Bout, ovfl;
  logic [7:0] D;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_d  = 8'h00;
  logic       exp_bo = 1'b0;
  logic       exp_ov = 1'b0;

  always #5 clk = ~clk;

  sub8_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout),
    .ovfl  (ovfl)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%02h expected=%02h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output logic [7:0] d, output logic bo, output logic ov);
    int ud, sd;
    ud = int'(a) - int'(b) - int'(bin);
    sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = ud[7:0];
    bo = (ud < 0);
    ov = (sd > 127) || (sd < -128);
`ifdef SUB8_SAT_EN
    if (ov) d = a[7] ? 8'h80 : 8'h7F;
`endif
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_d"}, D, exp_d);
    chk({tag, "_bout"}, 8'(Bout), 8'(exp_bo));
    chk({tag, "_ovfl"}, 8'(ovfl), 8'(exp_ov));
  endtask

  // Called at a negedge; returns at the negedge of the done cycle with start low.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit scramble);
    logic [7:0] nd;
    logic       nbo, nov;
    model(a, b, bin, nd, nbo, nov);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("run_busy", 8'(busy), 8'd1);
      chk("run_done", 8'(done), 8'd0);
      chk("run_hold_d", D, exp_d);
      if (scramble) begin
        A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom); start = 1'($urandom);
        if (c == 3) begin
          A = 8'hFF; start = 1'b1;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp_d = nd; exp_bo = nbo; exp_ov = nov;
    chk("done_pulse", 8'(done), 8'd1);
    chk("done_busy", 8'(busy), 8'd0);
    chk_outs("result");
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_done", 8'(done), 8'd0);
    chk("idle_busy", 8'(busy), 8'd0);
    chk_outs("idle_hold");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; A = 8'hAA; B = 8'h55; Bin = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk_outs("rst");
    rst_n = 1'b1; start = 1'b0;
    idle_cycle();

    do_op(8'h05, 8'h03, 1'b0, 1'b1);
    chk("req28_d", D, 8'h02);
    idle_cycle();
    do_op(8'h03, 8'h05, 1'b0, 1'b0);
    chk("req29_d", D, 8'hFE);
    chk("req29_bout", 8'(Bout), 8'd1);
    idle_cycle();
    do_op(8'h10, 8'h0F, 1'b1, 1'b0);
    idle_cycle();
    do_op(8'h80, 8'h01, 1'b0, 1'b0);
    chk("req30a_ovfl", 8'(ovfl), 8'd1);
    idle_cycle();
    do_op(8'h7F, 8'hFF, 1'b0, 1'b0);
    chk("req30b_ovfl", 8'(ovfl), 8'd1);
    idle_cycle();

    // Abort with reset at edge 5; the start seen alongside reset must be dropped.
    A = 8'h05; B = 8'h03; Bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0; start = 1'b1; A = 8'hFF;
    @(negedge clk);
    exp_d = 8'h00; exp_bo = 1'b0; exp_ov = 1'b0;
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_done", 8'(done), 8'd0);
    chk_outs("abort");
    rst_n = 1'b1; start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("abort_no_done", 8'(done), 8'd0);
      chk("abort_no_busy", 8'(busy), 8'd0);
    end
    do_op(8'h05, 8'h03, 1'b0, 1'b0);
    idle_cycle();

    // Back-to-back: start held high in DONE chains the next operation.
    do_op(8'h21, 8'h12, 1'b0, 1'b0);
    do_op(8'h00, 8'h01, 1'b1, 1'b0);
    do_op(8'hC0, 8'h40, 1'b1, 1'b1);
    idle_cycle();

    for (int n = 0; n < 40; n++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sub8_seq.md
SUB8_SEQ -- requirements
Module: sub8_seq

Interface
REQ-001 SHALL have no parameters; operand width fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 A  input  8  minuend, two's complement or unsigned.
REQ-006 B  input  8  subtrahend.
REQ-007 Bin  input  1  borrow-in.
REQ-008 busy  output  1  high while bits are processed.
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 D  output  8  difference A - B - Bin.
REQ-011 Bout  output  1  borrow out of bit 7 (unsigned A < B + Bin).
REQ-012 ovfl  output  1  signed overflow of the subtraction.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 IDLE + start=1 at edge k -> capture A, B, Bin into internal registers, clear bit counter, go to RUN; busy=1 from k+1.
REQ-015 RUN: one bit per cycle, LSB first; bit i uses borrow from bit i-1 (bit 0 uses captured Bin); bits computed at edges k+1..k+8.
REQ-016 After the 8th bit (edge k+8) -> DONE; done=1 and busy=0 for exactly the cycle after edge k+8; D, Bout, ovfl updated at edge k+8.
REQ-017 DONE -> IDLE next edge unless start=1, which starts a new operation as in REQ-014.
REQ-018 start while in RUN SHALL be ignored; A/B/Bin changes during RUN SHALL NOT affect the result.
REQ-019 D, Bout, ovfl SHALL hold their last values until the next operation completes; partial results SHALL NOT appear on D during RUN.
REQ-020 ovfl = (A[7] != B[7]) && (D_raw[7] != A[7]), where D_raw is the wrapped difference; Bout = final borrow.
REQ-021 Bit counter SHALL be 3 bits wide, wrapping 7 -> 0 exactly at the RUN -> DONE transition.

Reset
REQ-022 rst_n=0 at any edge -> state IDLE, busy=0, done=0, D=8'h00, Bout=0, ovfl=0, counter and operand registers cleared.
REQ-023 Reset during RUN SHALL abort the operation with no done pulse; start sampled in the same cycle as rst_n=0 SHALL be ignored.

Configuration
REQ-024 Macro SUB8_SAT_EN defined -> when ovfl=1, D SHALL be 8'h80 if A[7]=1 else 8'h7F; ovfl still reported, Bout unchanged.
REQ-025 SUB8_SAT_EN undefined -> D SHALL be the wrapped 8-bit difference; no saturation logic present.

Structure
REQ-026 Shared package SHALL hold the state encoding typedef (IDLE, RUN, DONE), WIDTH=8 constant, and saturation constants 8'h7F/8'h80.
REQ-027 One sub-module FS (1-bit full subtractor: x, y, Bin -> D, Bout) SHALL be instantiated once and reused every RUN cycle.

Verification
REQ-028 A=8'h05, B=8'h03, Bin=0, start at edge 0 -> done at cycle after edge 8, D=8'h02, Bout=0, ovfl=0.
REQ-029 A=8'h03, B=8'h05, Bin=0 -> D=8'hFE, Bout=1, ovfl=0; A=8'h10, B=8'h0F, Bin=1 -> D=8'h00, Bout=0.
REQ-030 A=8'h80, B=8'h01 -> ovfl=1, D=8'h7F (8'h80 with SUB8_SAT_EN); A=8'h7F, B=8'hFF -> ovfl=1, D=8'h80 (8'h7F with SUB8_SAT_EN), Bout=1.
REQ-031 start pulsed again at edge 4 with A=8'hFF -> ignored; first result 8'h02 delivered unchanged at edge 8.
REQ-032 rst_n=0 at edge 5 of an operation -> no done pulse, all outputs 0 next cycle, new start afterwards completes normally.
REQ-033 start held high in DONE -> back-to-back operations, done pulses every 9 cycles, no dropped request.
